// File: rtl/wash_phase_timer.sv
// Multi-round phase timer for the washing-machine controller.
// Runtime duration and round count, selectable prescale, pause and resume.
module wash_phase_timer #(
  parameter int BASE_TICKS = 1_000_000,
  parameter int CNT_W      = 32,
  parameter int SEC_W      = 12,
  parameter int ROUND_W    = 3
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_soft_rst,
  input  logic               i_start,
  input  logic               i_pause,
  input  logic [1:0]         i_clk_freq,
  input  logic [SEC_W-1:0]   i_duration_sec,
  input  logic [ROUND_W-1:0] i_rounds,
  output logic               o_busy,
  output logic               o_paused,
  output logic               o_round_done,
  output logic               o_all_done,
  output logic [SEC_W-1:0]   o_sec_elapsed,
  output logic [ROUND_W-1:0] o_round_cnt
);

  localparam logic [CNT_W-1:0] BASE_CNT = CNT_W'(BASE_TICKS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [1:0]         r_freq;
  logic [SEC_W-1:0]   r_dur;
  logic [ROUND_W-1:0] r_rounds;
  logic [CNT_W-1:0]   r_presc;
  logic [SEC_W-1:0]   r_sec;
  logic [ROUND_W-1:0] r_rcnt;
  logic               r_busy;
  logic               r_paused;
  logic               r_round_done;
  logic               r_all_done;

  logic               w_launch;
  logic               w_zero_cfg;
  logic               w_count;
  logic [CNT_W-1:0]   w_pm1;
  logic [CNT_W-1:0]   w_launch_pm1;
  logic               w_tick;
  logic               w_round_end;
  logic               w_last_round;
  logic [CNT_W-1:0]   w_presc_nxt;
  logic [SEC_W-1:0]   w_sec_nxt;
  logic               w_rd_run;
  logic               w_rd_launch;

  assign w_launch     = ((r_state == S_IDLE) || (r_state == S_DONE)) && i_start;
  assign w_zero_cfg   = (i_duration_sec == '0) || (i_rounds == '0);
  assign w_count      = ((r_state == S_RUN) || (r_state == S_PAUSE)) && !i_pause;
  assign w_pm1        = (BASE_CNT << r_freq) - CNT_W'(1);
  assign w_launch_pm1 = (BASE_CNT << i_clk_freq) - CNT_W'(1);

  assign w_tick       = w_count && (r_presc == w_pm1);
  assign w_round_end  = w_tick && (r_sec == r_dur - SEC_W'(1));
  assign w_last_round = w_round_end && ((r_rcnt + ROUND_W'(1)) == r_rounds);
  assign w_presc_nxt  = w_tick ? '0 : r_presc + CNT_W'(1);
  assign w_sec_nxt    = w_round_end ? '0 : (w_tick ? r_sec + SEC_W'(1) : r_sec);

  // round_done is registered one cycle ahead so it is high during the final
  // tick cycle itself; it is only armed on an edge that actually advanced
  // the prescaler, so a pause landing on the tick cannot produce a second pulse.
  assign w_rd_run     = w_count && !w_last_round && (w_presc_nxt == w_pm1) &&
                        (w_sec_nxt == r_dur - SEC_W'(1));
  assign w_rd_launch  = w_launch && !w_zero_cfg && (w_launch_pm1 == '0) &&
                        (i_duration_sec == SEC_W'(1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_freq       <= '0;
      r_dur        <= '0;
      r_rounds     <= '0;
      r_presc      <= '0;
      r_sec        <= '0;
      r_rcnt       <= '0;
      r_busy       <= 1'b0;
      r_paused     <= 1'b0;
      r_round_done <= 1'b0;
      r_all_done   <= 1'b0;
    end else if (!i_soft_rst) begin
      r_state      <= S_IDLE;
      r_freq       <= '0;
      r_dur        <= '0;
      r_rounds     <= '0;
      r_presc      <= '0;
      r_sec        <= '0;
      r_rcnt       <= '0;
      r_busy       <= 1'b0;
      r_paused     <= 1'b0;
      r_round_done <= 1'b0;
      r_all_done   <= 1'b0;
    end else begin
      r_round_done <= w_rd_run || w_rd_launch;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_freq   <= i_clk_freq;
            r_dur    <= i_duration_sec;
            r_rounds <= i_rounds;
            r_presc  <= '0;
            r_sec    <= '0;
            r_rcnt   <= '0;
            r_paused <= 1'b0;
            if (w_zero_cfg) begin
              r_state    <= S_DONE;
              r_busy     <= 1'b0;
              r_all_done <= 1'b1;
            end else begin
              r_state    <= S_RUN;
              r_busy     <= 1'b1;
              r_all_done <= 1'b0;
            end
          end
        end
        S_RUN, S_PAUSE: begin
          if (i_pause) begin
            r_state  <= S_PAUSE;
            r_paused <= 1'b1;
          end else begin
            r_presc  <= w_presc_nxt;
            r_sec    <= w_sec_nxt;
            r_paused <= 1'b0;
            if (w_round_end) begin
              r_rcnt <= r_rcnt + ROUND_W'(1);
            end
            if (w_last_round) begin
              r_state    <= S_DONE;
              r_busy     <= 1'b0;
              r_all_done <= 1'b1;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_paused      = r_paused;
  assign o_round_done  = r_round_done;
  assign o_all_done    = r_all_done;
  assign o_sec_elapsed = r_sec;
  assign o_round_cnt   = r_rcnt;

endmodule

// File: tb/tb_wash_phase_timer.sv
// Directed bench for wash_phase_timer with BASE_TICKS=4 so one second is 4 cycles at code 00.
// Table vectors are cumulative: each holds its inputs for n edges, then outputs are checked.
module tb_wash_phase_timer;

  logic        clk;
  logic        rst_n;
  logic        soft_rst;
  logic        start;
  logic        pause;
  logic [1:0]  clk_freq;
  logic [11:0] duration_sec;
  logic [2:0]  rounds;
  logic        busy;
  logic        paused;
  logic        round_done;
  logic        all_done;
  logic [11:0] sec_elapsed;
  logic [2:0]  round_cnt;

  int total;
  int bad;

  typedef struct {
    logic        sr;
    logic        st;
    logic        pa;
    logic [1:0]  f;
    logic [11:0] d;
    logic [2:0]  r;
    int          n;
    logic        eBusy;
    logic        ePaused;
    logic        eRd;
    logic        eAd;
    logic [11:0] eSec;
    logic [2:0]  eRc;
  } vec_t;

  vec_t vecs[$];

  wash_phase_timer #(
    .BASE_TICKS(4),
    .CNT_W(32),
    .SEC_W(12),
    .ROUND_W(3)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_soft_rst(soft_rst),
    .i_start(start),
    .i_pause(pause),
    .i_clk_freq(clk_freq),
    .i_duration_sec(duration_sec),
    .i_rounds(rounds),
    .o_busy(busy),
    .o_paused(paused),
    .o_round_done(round_done),
    .o_all_done(all_done),
    .o_sec_elapsed(sec_elapsed),
    .o_round_cnt(round_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void addVec(input logic sr, input logic st, input logic pa,
                                 input int f, input int d, input int r, input int n,
                                 input logic b, input logic p, input logic rd,
                                 input logic ad, input int s, input int rc);
    vec_t v;
    v.sr = sr; v.st = st; v.pa = pa;
    v.f = 2'(f); v.d = 12'(d); v.r = 3'(r); v.n = n;
    v.eBusy = b; v.ePaused = p; v.eRd = rd; v.eAd = ad;
    v.eSec = 12'(s); v.eRc = 3'(rc);
    vecs.push_back(v);
  endfunction

  task automatic checkField(input string tag, input int idx, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s step%0d actual=%0d required=%0d", tag, idx, actual, expected);
    end
  endtask

  task automatic checkOutput(input int idx, input logic b, input logic p, input logic rd,
                             input logic ad, input logic [11:0] s, input logic [2:0] rc);
    checkField("busy", idx, int'(busy), int'(b));
    checkField("paused", idx, int'(paused), int'(p));
    checkField("round_done", idx, int'(round_done), int'(rd));
    checkField("all_done", idx, int'(all_done), int'(ad));
    checkField("sec_elapsed", idx, int'(sec_elapsed), int'(s));
    checkField("round_cnt", idx, int'(round_cnt), int'(rc));
  endtask

  task automatic applyStimulus(input vec_t v);
    soft_rst     = v.sr;
    start        = v.st;
    pause        = v.pa;
    clk_freq     = v.f;
    duration_sec = v.d;
    rounds       = v.r;
    repeat (v.n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int cycles;
    int pulses;
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    soft_rst = 1'b1;
    start = 1'b0;
    pause = 1'b0;
    clk_freq = 2'b00;
    duration_sec = 12'd0;
    rounds = 3'd0;

    // D=3, R=2, P=4: round_done at 12 and 24; start and config changes while busy ignored
    addVec(1, 1, 0, 0, 3, 2, 1,   1, 0, 0, 0, 0, 0);
    addVec(1, 1, 0, 3, 5, 7, 4,   1, 0, 0, 0, 1, 0);
    addVec(1, 0, 0, 0, 3, 2, 7,   1, 0, 1, 0, 2, 0);
    addVec(1, 0, 0, 0, 3, 2, 1,   1, 0, 0, 0, 0, 1);
    addVec(1, 0, 0, 0, 3, 2, 11,  1, 0, 1, 0, 2, 1);
    addVec(1, 0, 0, 0, 3, 2, 1,   0, 0, 0, 1, 0, 2);
    addVec(1, 0, 0, 0, 3, 2, 5,   0, 0, 0, 1, 0, 2);
    // code 11, P=32, restarted from DONE; mid-run clk_freq change ignored
    addVec(1, 1, 0, 3, 3, 2, 1,   1, 0, 0, 0, 0, 0);
    addVec(1, 0, 0, 0, 9, 1, 95,  1, 0, 1, 0, 2, 0);
    addVec(1, 0, 0, 0, 9, 1, 1,   1, 0, 0, 0, 0, 1);
    addVec(1, 0, 0, 0, 9, 1, 95,  1, 0, 1, 0, 2, 1);
    addVec(1, 0, 0, 0, 9, 1, 1,   0, 0, 0, 1, 0, 2);
    // zero duration / zero rounds go straight to DONE
    addVec(1, 1, 0, 0, 0, 2, 1,   0, 0, 0, 1, 0, 0);
    addVec(1, 0, 0, 0, 0, 2, 3,   0, 0, 0, 1, 0, 0);
    addVec(1, 1, 0, 0, 3, 0, 1,   0, 0, 0, 1, 0, 0);
    addVec(1, 0, 0, 0, 3, 0, 2,   0, 0, 0, 1, 0, 0);
    // soft reset at cycle 7, priority over start, then a normal D=1 R=1 run
    addVec(1, 1, 0, 0, 3, 2, 1,   1, 0, 0, 0, 0, 0);
    addVec(1, 0, 0, 0, 3, 2, 6,   1, 0, 0, 0, 1, 0);
    addVec(0, 0, 0, 0, 3, 2, 1,   0, 0, 0, 0, 0, 0);
    addVec(0, 1, 0, 0, 3, 2, 2,   0, 0, 0, 0, 0, 0);
    addVec(1, 1, 0, 0, 1, 1, 1,   1, 0, 0, 0, 0, 0);
    addVec(1, 0, 0, 0, 1, 1, 3,   1, 0, 1, 0, 0, 0);
    addVec(1, 0, 0, 0, 1, 1, 1,   0, 0, 0, 1, 0, 1);
    // D=2 R=1 with pause held for 10 edges from cycle 5: round_done at 18
    addVec(1, 1, 0, 0, 2, 1, 1,   1, 0, 0, 0, 0, 0);
    addVec(1, 0, 0, 0, 2, 1, 4,   1, 0, 0, 0, 1, 0);
    addVec(1, 0, 1, 0, 2, 1, 1,   1, 1, 0, 0, 1, 0);
    addVec(1, 0, 1, 0, 2, 1, 9,   1, 1, 0, 0, 1, 0);
    addVec(1, 0, 0, 0, 2, 1, 3,   1, 0, 1, 0, 1, 0);
    addVec(1, 0, 0, 0, 2, 1, 1,   0, 0, 0, 1, 0, 1);

    @(negedge clk);
    @(negedge clk);
    checkOutput(-1, 0, 0, 0, 0, 12'd0, 3'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(i, vecs[i].eBusy, vecs[i].ePaused, vecs[i].eRd, vecs[i].eAd,
                  vecs[i].eSec, vecs[i].eRc);
    end

    // asynchronous reset mid-cycle clears outputs without a clock edge
    start = 1'b1; duration_sec = 12'd2; rounds = 3'd2; clk_freq = 2'b00;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    checkField("pre_async_busy", 100, int'(busy), 1);
    checkField("pre_async_sec", 100, int'(sec_elapsed), 1);
    rst_n = 1'b0;
    #1;
    checkField("async_busy", 101, int'(busy), 0);
    checkField("async_sec", 101, int'(sec_elapsed), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // bounded run D=2 R=2: two pulses, all_done 16 cycles after start
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    pulses = 0;
    while (cycles < 60 && !all_done) begin
      @(posedge clk);
      @(negedge clk);
      cycles++;
      if (round_done) pulses++;
    end
    checkField("run_all_done", 102, int'(all_done), 1);
    checkField("run_cycles", 102, cycles, 16);
    checkField("run_pulses", 102, pulses, 2);
    checkField("run_round_cnt", 102, int'(round_cnt), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wash_phase_timer.md
# wash_phase_timer

Parametrised, multi-round phase timer for the washing-machine controller. It generalises the fixed-duration per-phase counters: duration in seconds and round count are runtime inputs, the clock-frequency code selects the prescale, and pause/resume is supported. One instance serves any of the filling, washing, rinsing or spinning phases under the main controller FSM.

## Interface
- BASE_TICKS, 1_000_000: clk cycles per second when clk_freq = 2'b00 (1 MHz); code k gives BASE_TICKS << k cycles per second.
- CNT_W, 32: prescaler width; must hold (BASE_TICKS << 3) - 1.
- SEC_W, 12: width of duration_sec and sec_elapsed.
- ROUND_W, 3: width of rounds and round_cnt.

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- soft_rst  in  1  synchronous active-low clear; same effect as rst_n, applied at the clock edge
- start  in  1  start request; sampled only in IDLE or DONE
- pause  in  1  level; high freezes timing while running
- clk_freq  in  2  frequency code (00/01/10/11 = BASE, 2x, 4x, 8x); latched at start
- duration_sec  in  SEC_W  seconds per round; latched at start
- rounds  in  ROUND_W  number of rounds; latched at start
- busy  out  1  high in RUN or PAUSE
- paused  out  1  high in PAUSE
- round_done  out  1  one-cycle pulse at the end of each round
- all_done  out  1  level; high in DONE
- sec_elapsed  out  SEC_W  whole seconds completed in the current round
- round_cnt  out  ROUND_W  rounds completed

## Operation
- States: IDLE, RUN, PAUSE, DONE. Reset state is IDLE. All outputs and internal counters are 0 at reset.
- Prescale period P = BASE_TICKS << clk_freq_latched. The prescaler counts 0 to P-1; the cycle in which it reaches P-1 is a second tick, and the prescaler wraps to 0.
- IDLE or DONE, with start = 1:
  - Latch clk_freq, duration_sec and rounds.
  - Clear the prescaler, sec_elapsed and round_cnt.
  - Go to RUN.
  - If the latched duration_sec = 0 or rounds = 0, go to DONE instead. No round_done pulse is produced.
- RUN, with pause = 1: go to PAUSE. The prescaler does not advance in the cycle pause is sampled.
- PAUSE: all counters hold. When pause = 0, go to RUN and resume counting on the next cycle.
- RUN, on a second tick:
  - If sec_elapsed = duration-1: pulse round_done, clear sec_elapsed and increment round_cnt.
  - If round_cnt+1 = rounds, go to DONE.
  - Otherwise sec_elapsed increments.
- Consecutive rounds run back to back with no idle cycles between them.
- DONE: all_done stays high, and round_cnt and sec_elapsed hold, until start or a reset. A start in DONE restarts with fresh latched configuration.
- start while busy is ignored. Changes to clk_freq, duration_sec or rounds while busy are ignored.
- If pause and a second tick occur in the same cycle, pause wins: no tick, and the prescaler holds at P-1.
- soft_rst = 0 in any state returns to IDLE with all outputs cleared. It has priority over start.

## Timing
- A start sampled at edge E0 gives busy = 1 after E0.
- The first round_done is high for exactly the cycle ending at edge E0 + D*P, where D = duration_sec.
- Round n completes at E0 + n*D*P, plus the total number of cycles spent paused.
- all_done rises at the same edge at which the final round_done pulse ends, i.e. it is registered together with the DONE transition. busy falls at that same edge.
- The zero-duration or zero-rounds case gives all_done = 1 one cycle after start.
- Outputs are registered. No combinational path runs from inputs to outputs.

## Test plan
- BASE_TICKS=4, clk_freq=00, duration_sec=3, rounds=2, start pulse -> round_done pulses at 12 and 24 cycles after start; all_done rises at 24; round_cnt=2.
- Same configuration with clk_freq=11 -> P=32; round_done at 96 and 192; a clk_freq change mid-run has no effect.
- Run with duration_sec=2, rounds=1; pause held for 10 cycles at cycle 5 -> round_done at cycle 18; sec_elapsed frozen and paused=1 throughout the pause.
- duration_sec=0 or rounds=0 -> all_done=1 one cycle after start, no round_done, busy never 1.
- soft_rst=0 mid-run (cycle 7) -> next cycle: IDLE, busy=0, all outputs 0; a later start runs normally.
- rst_n asserted asynchronously mid-cycle -> outputs 0 immediately. A start issued while busy is ignored; a start issued in DONE restarts with the new duration_sec.
